// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } lsu_state_e;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

endpackage

// File: rtl/lsu_if.sv
// Word-oriented memory bus between the LSU (master) and the data memory (slave).
interface lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = load_word_i[{offset_i, 3'b000} +: 8];
  assign half_sel = load_word_i[{offset_i[1], 4'b0000} +: 16];

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = store_data_i;
    case (funct3_i)
      LSU_B: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      LSU_H: begin
        be_o    = 4'b0011 << {offset_i[1], 1'b0};
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (funct3_i)
      LSU_B:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
      LSU_H:   load_data_o = {{16{half_sel[15]}}, half_sel};
      LSU_BU:  load_data_o = {24'h0, byte_sel};
      LSU_HU:  load_data_o = {16'h0, half_sel};
      default: load_data_o = load_word_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one access at a time over a req/gnt/rvalid bus, stalling the core meanwhile.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AccessErr,
  lsu_if.master       mem
);

  lsu_state_e  state_q;
  logic [29:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic [31:0] rdata_q;

  logic        is_idle, size_ok, align_ok, legal;
  logic [2:0]  sel_funct3;
  logic [1:0]  sel_offset;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_load;

  always_comb begin
    case (funct3)
      LSU_B, LSU_H, LSU_W: size_ok = 1'b1;
      LSU_BU, LSU_HU:      size_ok = MemRead;  // unsigned forms exist only for loads
      default:             size_ok = 1'b0;
    endcase
    case (funct3)
      LSU_H, LSU_HU: align_ok = ~ALUResult[0];
      LSU_W:         align_ok = (ALUResult[1:0] == 2'b00);
      default:       align_ok = 1'b1;
    endcase
  end

  assign is_idle   = (state_q == StIdle);
  assign legal     = (MemRead ^ MemWrite) & size_ok & align_ok;
  assign Stall     = (is_idle & legal) | (state_q == StReq) | (state_q == StWait);
  assign AccessErr = is_idle & (MemRead | MemWrite) & ~legal;

  // Idle steers the incoming store; later states extract the load with registered selectors.
  assign sel_funct3 = is_idle ? funct3 : funct3_q;
  assign sel_offset = is_idle ? ALUResult[1:0] : offset_q;

  lsu_align u_align (
    .funct3_i     (sel_funct3),
    .offset_i     (sel_offset),
    .store_data_i (WriteData),
    .load_word_i  (mem.mem_rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .load_data_o  (al_load)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      offset_q <= '0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (legal) begin
            addr_q   <= ALUResult[31:2];
            be_q     <= MemWrite ? al_be : 4'b1111;
            wdata_q  <= al_wdata;
            we_q     <= MemWrite;
            funct3_q <= funct3;
            offset_q <= ALUResult[1:0];
            state_q  <= StReq;
          end
        end
        StReq: begin
          if (mem.mem_gnt) state_q <= we_q ? StDone : StWait;
        end
        StWait: begin
          if (mem.mem_rvalid) begin
            rdata_q <= al_load;
            state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ReadData      = rdata_q;
  assign mem.mem_req   = (state_q == StReq);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = {addr_q, 2'b00};
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 MemRead  in  1  load request from control; held stable by core while Stall=1.
REQ-004 MemWrite  in  1  store request from control; held stable while Stall=1.
REQ-005 funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-006 ALUResult  in  32  byte address from datapath.
REQ-007 WriteData  in  32  store data (rs2) from datapath.
REQ-008 ReadData  out  32  extended load result to datapath result mux.
REQ-009 Stall  out  1  freeze PC/regfile while access in flight.
REQ-010 AccessErr  out  1  misaligned or illegal access, pulse in IDLE.
REQ-011 mem_req  out  1  memory request, held until mem_gnt.
REQ-012 mem_we  out  1  1=write, 0=read; valid with mem_req.
REQ-013 mem_addr  out  32  word address {addr[31:2],2'b00}.
REQ-014 mem_be  out  4  byte enables (writes; 4'b1111 on reads).
REQ-015 mem_wdata  out  32  lane-replicated store data.
REQ-016 mem_gnt  in  1  request accepted this cycle.
REQ-017 mem_rvalid  in  1  read data valid; earliest cycle after mem_gnt.
REQ-018 mem_rdata  in  32  read word.

Function
REQ-019 FSM states IDLE, REQ, WAIT, DONE.
REQ-020 IDLE: legal MemRead xor MemWrite -> register addr/be/wdata/we/funct3/offset, Stall=1, go REQ; else stay, Stall=0.
REQ-021 REQ: mem_req=1, outputs from registers; mem_gnt=1 -> WAIT if read, DONE if write; else stay.
REQ-022 WAIT: mem_rvalid=1 -> capture extended data into ReadData, go DONE; else stay.
REQ-023 DONE: Stall=0 exactly one cycle, no request issued; next state IDLE unconditionally.
REQ-024 Stall=1 combinationally in IDLE when a legal access is detected, and in REQ and WAIT.
REQ-025 Minimum Stall: load 3 cycles, store 2 cycles (gnt in first REQ cycle, rvalid next).
REQ-026 Store steering: B -> be=4'b0001<<addr[1:0], wdata={4{WriteData[7:0]}}; H -> be=4'b0011<<{addr[1],1'b0}, wdata={2{WriteData[15:0]}}; W -> be=4'b1111.
REQ-027 Load extract at registered offset: B/H sign-extend, BU/HU zero-extend, W as-is.
REQ-028 AccessErr=1 (IDLE only, no request, Stall=0): H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 011/110/111; store funct3 not 000/001/010; MemRead and MemWrite both 1.
REQ-029 ReadData held until next completed load; unchanged by stores and errors.
REQ-030 mem_rvalid outside WAIT and mem_gnt outside REQ ignored.

Reset
REQ-031 rst=1 at an edge -> state IDLE, ReadData=0, internal registers 0, mem_req=0, Stall=0 from that edge; an in-flight access is abandoned without retry.
REQ-032 rst dominates all other inputs in the same cycle.

Structure
REQ-033 lsu_pkg holds state enum and funct3 constants (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU).
REQ-034 Combinational lane steering/extension in one sub-module lsu_align, shared by store and load paths.
REQ-035 Target 120-400 lines RTL total.

Verification
REQ-036 SW x=0xDEADBEEF at 0x100, gnt first cycle -> mem_addr=0x100, be=1111, wdata=0xDEADBEEF, Stall 2 cycles.
REQ-037 LB at 0x103, rdata=0x80FFFFFF -> ReadData=0xFFFFFF80; LBU same -> 0x00000080; Stall 3 cycles.
REQ-038 SH 0x1234 at 0x102 -> be=1100, wdata=0x12341234; LHU 0x102 on rdata 0xABCD0000 -> 0x0000ABCD.
REQ-039 LW at 0x101 -> AccessErr=1 one cycle, mem_req never asserted, Stall=0; ReadData unchanged.
REQ-040 LW with gnt delayed 4 cycles, rvalid 2 cycles later -> mem_req held steady 5 cycles, Stall high until DONE, spurious rvalid during REQ ignored.
REQ-041 rst asserted in WAIT -> IDLE next edge, ReadData=0, Stall=0; subsequent rvalid ignored.
